// File: rtl/wb_ser_scheduler.sv
// Wishbone master sharing the serializer write port among NREQ requesters.
// Round-robin grant, one registered WB write per grant, comma idle words
// when the link is quiet, and abort of cycles that never get a response.
module wb_ser_scheduler #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] ADR_SER   = 32'h0000_0000,
    parameter int          TIMEOUT   = 4096,
    parameter bit          IDLE_EN   = 1'b1,
    parameter int          IDLE_GAP  = 64,
    parameter logic [31:0] IDLE_WORD = {5'b0, 9'h1BC, 9'h1BC, 9'h1BC}
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*32-1:0]   data_i,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic                 busy_o,
    output logic [15:0]          tx_count_o,
    output logic                 CYC_O,
    output logic                 STB_O,
    output logic                 WE_O,
    output logic [31:0]          ADR_O,
    output logic [31:0]          DAT_O,
    input  logic                 ACK_I,
    input  logic                 ERR_I
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TOW  = $clog2(TIMEOUT) + 1;
    localparam int IGW  = $clog2(IDLE_GAP) + 1;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);
    localparam logic [TOW-1:0]  TO_LAST   = TOW'(TIMEOUT - 1);
    localparam logic [IGW-1:0]  IDLE_LAST = IGW'(IDLE_GAP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_RESP} state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   owner_reg, owner_next;
    logic              owned_reg, owned_next;
    logic [IDXW-1:0]   rr_reg, rr_next;
    logic [IGW-1:0]    idle_cnt_reg, idle_cnt_next;
    logic [TOW-1:0]    to_cnt_reg, to_cnt_next;
    logic [15:0]       tx_count_reg, tx_count_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [NREQ-1:0]   err_reg, err_next;
    logic              cyc_reg, cyc_next;
    logic              we_reg, we_next;
    logic [31:0]       adr_reg, adr_next;
    logic [31:0]       dat_reg, dat_next;

    logic [31:0]       data_arr [NREQ];
    logic [NREQ-1:0]   at_or_above_rr;
    logic [NREQ-1:0]   owner_hot;
    logic [NREQ-1:0]   req_hi;
    logic              found_any, found_hi;
    logic [IDXW-1:0]   idx_lo, idx_hi, win_idx;

    // Per-requester views: data word, position relative to rr, owner decode
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign data_arr[gi]       = data_i[gi*32 +: 32];
            assign at_or_above_rr[gi] = (IDXW'(gi) >= rr_reg);
            assign owner_hot[gi]      = (owner_reg == IDXW'(gi));
        end
    endgenerate

    assign req_hi = req_i & at_or_above_rr;

    // Round-robin pick: lowest request at/above rr, else lowest overall (wrap)
    always_comb begin
        found_any = 1'b0;
        found_hi  = 1'b0;
        idx_lo    = '0;
        idx_hi    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_any = 1'b1;
                idx_lo    = IDXW'(i);
            end
            if (req_hi[i]) begin
                found_hi = 1'b1;
                idx_hi   = IDXW'(i);
            end
        end
        win_idx = found_hi ? idx_hi : idx_lo;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        owned_next    = owned_reg;
        rr_next       = rr_reg;
        idle_cnt_next = idle_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        tx_count_next = tx_count_reg;
        done_next     = '0;
        err_next      = '0;
        cyc_next      = cyc_reg;
        we_next       = we_reg;
        adr_next      = adr_reg;
        dat_next      = dat_reg;

        case (state_reg)
            ST_IDLE: begin
                if (found_any) begin
                    // A request beats a coincident idle trigger
                    state_next    = ST_WRITE;
                    owner_next    = win_idx;
                    owned_next    = 1'b1;
                    cyc_next      = 1'b1;
                    we_next       = 1'b1;
                    adr_next      = ADR_SER;
                    dat_next      = data_arr[win_idx];
                    idle_cnt_next = '0;
                    to_cnt_next   = '0;
                end else if (IDLE_EN && (idle_cnt_reg == IDLE_LAST)) begin
                    state_next    = ST_WRITE;
                    owned_next    = 1'b0;
                    cyc_next      = 1'b1;
                    we_next       = 1'b1;
                    adr_next      = ADR_SER;
                    dat_next      = IDLE_WORD;
                    idle_cnt_next = '0;
                    to_cnt_next   = '0;
                end else if (idle_cnt_reg != IDLE_LAST) begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            ST_WRITE: begin
                to_cnt_next = to_cnt_reg + 1'b1;
                if (ACK_I || ERR_I || (to_cnt_reg == TO_LAST)) begin
                    state_next = ST_RESP;
                    cyc_next   = 1'b0;
                    we_next    = 1'b0;
                    adr_next   = '0;
                    dat_next   = '0;
                    if (owned_reg) begin
                        rr_next = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
                    end
                    // Only a clean ACK counts as a delivered word
                    if (ACK_I && !ERR_I) begin
                        tx_count_next = tx_count_reg + 16'd1;
                        if (owned_reg) begin
                            done_next = owner_hot;
                        end
                    end else if (owned_reg) begin
                        err_next = owner_hot;
                    end
                end
            end
            ST_RESP: begin
                // Dead cycle keeps CYC_O low so the serializer re-arms
                to_cnt_next = '0;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            owned_reg    <= 1'b0;
            rr_reg       <= '0;
            idle_cnt_reg <= '0;
            to_cnt_reg   <= '0;
            tx_count_reg <= '0;
            done_reg     <= '0;
            err_reg      <= '0;
            cyc_reg      <= 1'b0;
            we_reg       <= 1'b0;
            adr_reg      <= '0;
            dat_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            owned_reg    <= owned_next;
            rr_reg       <= rr_next;
            idle_cnt_reg <= idle_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            tx_count_reg <= tx_count_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            cyc_reg      <= cyc_next;
            we_reg       <= we_next;
            adr_reg      <= adr_next;
            dat_reg      <= dat_next;
        end
    end

    assign CYC_O      = cyc_reg;
    assign STB_O      = cyc_reg;
    assign WE_O       = we_reg;
    assign ADR_O      = adr_reg;
    assign DAT_O      = dat_reg;
    assign busy_o     = cyc_reg;
    assign done_o     = done_reg;
    assign err_o      = err_reg;
    assign tx_count_o = tx_count_reg;

endmodule

// File: tb/tb_wb_ser_scheduler.sv
// Self-checking bench for wb_ser_scheduler: randomized requester bursts and
// WB responses compared against a transaction-level round-robin model.
module tb_wb_ser_scheduler;

    localparam logic [31:0] ADR = 32'hA000_0010;
    localparam logic [31:0] IDLE_W = {5'b0, 9'h1BC, 9'h1BC, 9'h1BC};

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic [3:0]    req_i = '0;
    logic [127:0]  data_i;
    logic [3:0]    done_o, err_o;
    logic          busy_o;
    logic [15:0]   tx_count_o;
    logic          CYC_O, STB_O, WE_O;
    logic [31:0]   ADR_O, DAT_O;
    logic          ACK_I = 1'b0;
    logic          ERR_I = 1'b0;

    logic [31:0]   data_w [4];
    assign data_i = {data_w[3], data_w[2], data_w[1], data_w[0]};

    // Reference model state
    int            rr_m;
    logic [15:0]   tx_m;
    int            next_wait;

    int            checks = 0;
    int            errors = 0;

    wb_ser_scheduler #(
        .NREQ(4), .ADR_SER(ADR), .TIMEOUT(16), .IDLE_EN(1'b1), .IDLE_GAP(8)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .req_i(req_i), .data_i(data_i),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .tx_count_o(tx_count_o),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .ACK_I(ACK_I), .ERR_I(ERR_I)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] p, input int rr);
        for (int k = 0; k < 4; k++) begin
            if (p[(rr + k) % 4]) return (rr + k) % 4;
        end
        return 0;
    endfunction

    function automatic int pick_mode();
        int r;
        r = $urandom_range(0, 7);
        if (r <= 3) return 0;      // ACK
        if (r <= 5) return 1;      // ERR
        if (r == 6) return 2;      // ACK+ERR
        return 3;                  // no response
    endfunction

    task automatic rand_data();
        for (int k = 0; k < 4; k++) data_w[k] = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cyc"}, CYC_O, 0);
        check_val({tag, "_stb"}, STB_O, 0);
        check_val({tag, "_we"}, WE_O, 0);
        check_val({tag, "_adr"}, ADR_O, 0);
        check_val({tag, "_dat"}, DAT_O, 0);
        check_val({tag, "_done"}, done_o, 0);
        check_val({tag, "_err"}, err_o, 0);
        check_val({tag, "_busy"}, busy_o, 0);
        check_val({tag, "_tx"}, tx_count_o, 0);
    endtask

    task automatic do_reset();
        RST_I = 1'b1;
        req_i = '0;
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        repeat (3) step();
        check_all_zero("rst");
        RST_I = 1'b0;
        rr_m = 0;
        tx_m = '0;
        next_wait = 1;
    endtask

    // Answers an open cycle; ends on the step where the pulse is visible
    task automatic respond(input int mode, input int dly, input logic [3:0] hot);
        int n;
        if (mode != 3) begin
            repeat (dly) step();
            check_val("hold_cyc", CYC_O, 1);
            ACK_I = (mode != 1);
            ERR_I = (mode != 0);
            step();
            ACK_I = 1'b0;
            ERR_I = 1'b0;
        end else begin
            n = 0;
            while (CYC_O && n < 40) begin
                step();
                n++;
            end
            check_val("timeout_len", n, 16);
        end
        if (mode == 0) tx_m = tx_m + 16'd1;
        check_val("drop_cyc", CYC_O, 0);
        check_val("drop_stb", STB_O, 0);
        check_val("drop_busy", busy_o, 0);
        check_val("drop_adr", ADR_O, 0);
        check_val("drop_we", WE_O, 0);
        check_val("done", done_o, (mode == 0) ? hot : 4'b0);
        check_val("err", err_o, (mode != 0) ? hot : 4'b0);
        check_val("tx_count", tx_count_o, tx_m);
    endtask

    // Holds mask, serves every requester in round-robin order until all drop
    task automatic serve(input logic [3:0] mask, input int mode_in, input int dly_in);
        logic [3:0] pend;
        int w, n, mode, dly;
        pend = mask;
        req_i = pend;
        while (pend != 4'b0) begin
            w = winner(pend, rr_m);
            n = 0;
            while (!CYC_O && n < 40) begin
                step();
                n++;
            end
            check_val("grant_lat", n, next_wait);
            if (!CYC_O) begin
                req_i = '0;
                return;
            end
            check_val("grant_dat", DAT_O, data_w[w]);
            check_val("grant_adr", ADR_O, ADR);
            check_val("grant_we", WE_O, 1);
            check_val("grant_stb", STB_O, 1);
            check_val("grant_busy", busy_o, 1);
            mode = (mode_in > 3) ? pick_mode() : mode_in;
            dly  = (dly_in < 0) ? $urandom_range(0, 10) : dly_in;
            respond(mode, dly, 4'(1 << w));
            $display("txn req=%0d mode=%0d dly=%0d tx=%0d", w, mode, dly, tx_m);
            pend[w] = 1'b0;
            req_i = pend;
            step();
            check_val("pulse_done_clr", done_o, 0);
            check_val("pulse_err_clr", err_o, 0);
            rr_m = (w + 1) % 4;
            next_wait = 1;
        end
    endtask

    // Expects a comma idle cycle exactly IDLE_GAP cycles into a quiet link
    task automatic idle_check();
        int n, mode, dly;
        req_i = '0;
        n = 0;
        while (!CYC_O && n < 40) begin
            step();
            n++;
        end
        check_val("idle_lat", n, 8);
        if (!CYC_O) return;
        check_val("idle_dat", DAT_O, IDLE_W);
        check_val("idle_adr", ADR_O, ADR);
        mode = pick_mode();
        dly  = $urandom_range(0, 10);
        respond(mode, dly, 4'b0);
        $display("txn idle mode=%0d dly=%0d tx=%0d", mode, dly, tx_m);
        step();
        next_wait = 1;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 4; k++) data_w[k] = '0;

        do_reset();
        rand_data();
        data_w[0] = 32'h0001_2345;
        serve(4'b0001, 0, 10);

        rand_data();
        serve(4'b1011, 0, -1);
        rand_data();
        serve(4'b1111, 4, -1);

        rand_data();
        serve(4'b0100, 3, 0);
        rand_data();
        serve(4'b0010, 2, -1);
        rand_data();
        serve(4'b1111, 0, -1);

        idle_check();
        // Responses with no open cycle must be ignored
        ACK_I = 1'b1;
        repeat (3) step();
        ACK_I = 1'b0;
        check_val("stray_ack_tx", tx_count_o, tx_m);
        check_val("stray_ack_done", done_o, 0);
        check_val("stray_ack_busy", busy_o, 0);
        rand_data();
        serve(4'($urandom_range(1, 15)), 4, -1);

        do_reset();
        idle_check();

        // Reset pulsed in the middle of an open cycle
        rand_data();
        req_i = 4'b0101;
        n = 0;
        while (!CYC_O && n < 40) begin
            step();
            n++;
        end
        check_val("mid_grant_lat", n, next_wait);
        repeat (3) step();
        RST_I = 1'b1;
        step();
        check_all_zero("mid_rst");
        RST_I = 1'b0;
        rr_m = 0;
        tx_m = '0;
        next_wait = 1;
        serve(4'b0101, 4, -1);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                idle_check();
            end else begin
                rand_data();
                serve(4'($urandom_range(1, 15)), 4, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
